// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_unit
//  Description : Instruction fetch stage. Issues single-outstanding requests
//                on the imem req/ack port, buffers returned words with their
//                PC+4 in a prefetch FIFO and presents the head to IF/ID.
//                Redirects flush the buffer and restart fetch at a new PC.
//  Options     : IF_ALIGN_FAULT_EN - misaligned redirect raises a sticky
//                fault and halts fetch; otherwise redirect_pc[1:0] is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        fd_ready,
    output logic        fd_valid,
    output logic [31:0] fd_ins,
    output logic [31:0] fd_next_pc
`ifdef IF_ALIGN_FAULT_EN
    ,
    output logic        fault
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic             imem_req_q, imem_req_d;
    logic [31:0]      imem_addr_q, imem_addr_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic             drop_q, drop_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      fifo_ins_q [FIFO_DEPTH];
    logic [31:0]      fifo_ins_d [FIFO_DEPTH];
    logic [31:0]      fifo_npc_q [FIFO_DEPTH];
    logic [31:0]      fifo_npc_d [FIFO_DEPTH];

    logic        halt;
    logic        issue;
    logic        push;
    logic        pop;
    logic [31:0] redirect_target;

`ifdef IF_ALIGN_FAULT_EN
    logic fault_q, fault_d;
    logic misalign;

    assign misalign        = redirect && (redirect_pc[1:0] != 2'b00);
    assign halt            = fault_q;
    assign redirect_target = redirect_pc;
    assign fault           = fault_q;
`else
    // Low PC bits are deliberately discarded in this build.
    logic unused_pc_lsbs;

    assign unused_pc_lsbs  = ^redirect_pc[1:0];
    assign halt            = 1'b0;
    assign redirect_target = {redirect_pc[31:2], 2'b00};
`endif

    // A request may only start from IDLE, with no redirect pending and room
    // for its word (nothing else is outstanding in IDLE).
    assign issue = (state_q == S_IDLE) && !redirect && !halt && (count_q < DEPTH_C);
    assign push  = (state_q == S_WAIT) && imem_ack && !drop_q && !redirect;
    assign pop   = fd_valid && fd_ready && !redirect;

    assign fd_valid   = (count_q != '0);
    assign fd_ins     = fd_valid ? fifo_ins_q[rd_ptr_q] : 32'h0;
    assign fd_next_pc = fd_valid ? fifo_npc_q[rd_ptr_q] : 32'h0;
    assign imem_req   = imem_req_q;
    assign imem_addr  = imem_addr_q;

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            imem_req_q  <= 1'b0;
            imem_addr_q <= RESET_PC;
            fetch_pc_q  <= RESET_PC;
            drop_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_ins_q[i] <= 32'h0;
                fifo_npc_q[i] <= 32'h0;
            end
`ifdef IF_ALIGN_FAULT_EN
            fault_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            fetch_pc_q  <= fetch_pc_d;
            drop_q      <= drop_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            fifo_ins_q  <= fifo_ins_d;
            fifo_npc_q  <= fifo_npc_d;
`ifdef IF_ALIGN_FAULT_EN
            fault_q     <= fault_d;
`endif
        end
    end

    // Next-state: IDLE starts a request when allowed, WAIT ends on ack.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (issue)    state_d = S_WAIT;
            S_WAIT:  if (imem_ack) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Registered imem port: address latched at issue, held through WAIT.
    always_comb begin
        imem_req_d  = imem_req_q;
        imem_addr_d = imem_addr_q;
        if (issue) begin
            imem_req_d  = 1'b1;
            imem_addr_d = fetch_pc_q;
        end else if ((state_q == S_WAIT) && imem_ack) begin
            imem_req_d  = 1'b0;
        end
    end

    // FIFO, fetch PC, drop flag and fault: redirect overrides push and pop.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        drop_d     = drop_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        fifo_ins_d = fifo_ins_q;
        fifo_npc_d = fifo_npc_q;
`ifdef IF_ALIGN_FAULT_EN
        fault_d    = fault_q;
        if (misalign) fault_d = 1'b1;
`endif

        if ((state_q == S_WAIT) && imem_ack) drop_d = 1'b0;

        if (push) begin
            fifo_ins_d[wr_ptr_q] = imem_rdata;
            fifo_npc_d[wr_ptr_q] = fetch_pc_q + 32'd4;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
            fetch_pc_d           = fetch_pc_q + 32'd4;
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (redirect) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            fetch_pc_d = redirect_target;
            // The in-flight word belongs to the old stream; mark it for discard.
            if ((state_q == S_WAIT) && !imem_ack) drop_d = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_fetch_unit
//  Description : Directed self-checking bench for if_fetch_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fd_ready;
    logic        fd_valid;
    logic [31:0] fd_ins;
    logic [31:0] fd_next_pc;
`ifdef IF_ALIGN_FAULT_EN
    logic        fault;
`endif

    logic auto_ack;
    logic man_ack;
    int   checks   = 0;
    int   failures = 0;

    localparam logic [31:0] KEY = 32'hDEAD_0000;

    always #5 clk = ~clk;

    // Memory model: word content is the address tagged with KEY.
    assign imem_ack   = auto_ack ? imem_req : man_ack;
    assign imem_rdata = imem_addr ^ KEY;

    if_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fd_ready    (fd_ready),
        .fd_valid    (fd_valid),
        .fd_ins      (fd_ins),
        .fd_next_pc  (fd_next_pc)
`ifdef IF_ALIGN_FAULT_EN
        ,
        .fault       (fault)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n     = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        fd_ready    = 1'b0;
        auto_ack    = 1'b0;
        man_ack     = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        fd_ready = 1'b0; auto_ack = 1'b0; man_ack = 1'b0;
        tick();
        tick();
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr: got %h expected 00000000", imem_addr); end
        checks++; if (fd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", fd_valid); end
        checks++; if (fd_ins !== 32'h0 || fd_next_pc !== 32'h0) begin failures++; $display("FAIL reset_head: got %h/%h expected 0/0", fd_ins, fd_next_pc); end
        reset_n = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL reset_first_req: got %b/%h expected 1/00000000", imem_req, imem_addr); end
    endtask

    // Zero-wait memory, consumer always ready: one word every two cycles.
    task automatic test_stream();
        logic [31:0] exp_addr;
        logic [31:0] exp_npc;
        apply_reset();
        auto_ack = 1'b1;
        fd_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_addr = 32'(4 * ((k - 1) / 2));
            checks++; if (imem_addr !== exp_addr || imem_req !== 1'(k % 2)) begin failures++; $display("FAIL stream_addr[%0d]: got %b/%h expected %b/%h", k, imem_req, imem_addr, 1'(k % 2), exp_addr); end
            if (k % 2 == 0) begin
                exp_npc = 32'(4 * (k / 2));
                checks++; if (fd_valid !== 1'b1 || fd_next_pc !== exp_npc || fd_ins !== ((exp_npc - 32'd4) ^ KEY)) begin failures++; $display("FAIL stream_head[%0d]: got %b/%h/%h expected 1/%h/%h", k, fd_valid, fd_next_pc, fd_ins, exp_npc, (exp_npc - 32'd4) ^ KEY); end
            end else begin
                checks++; if (fd_valid !== 1'b0) begin failures++; $display("FAIL stream_empty[%0d]: got %b expected 0", k, fd_valid); end
            end
        end
    endtask

    // Stalled consumer fills the FIFO; one pop frees exactly one request.
    task automatic test_full();
        int          acks;
        logic [31:0] ack_addr;
        apply_reset();
        auto_ack = 1'b1;
        acks = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (imem_req && imem_ack) acks++;
        end
        checks++; if (acks !== 4) begin failures++; $display("FAIL full_acks: got %0d expected 4", acks); end
        checks++; if (imem_req !== 1'b0 || fd_next_pc !== 32'h4) begin failures++; $display("FAIL full_idle: got %b/%h expected 0/00000004", imem_req, fd_next_pc); end
        fd_ready = 1'b1;
        tick();
        fd_ready = 1'b0;
        acks = 0;
        ack_addr = 32'hFFFF_FFFF;
        for (int k = 0; k < 10; k++) begin
            if (imem_req && imem_ack) begin acks++; ack_addr = imem_addr; end
            tick();
        end
        checks++; if (acks !== 1 || ack_addr !== 32'h10) begin failures++; $display("FAIL full_refill: got %0d acks addr %h expected 1 acks addr 00000010", acks, ack_addr); end
        checks++; if (fd_next_pc !== 32'h8) begin failures++; $display("FAIL full_head_after_pop: got %h expected 00000008", fd_next_pc); end
    endtask

    // Redirect while a request waits; the late ack must be discarded.
    task automatic test_redirect_wait();
        apply_reset();
        tick();
        redirect = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL rw_hold: got %b/%h expected 1/00000000", imem_req, imem_addr); end
        tick();
        tick();
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        checks++; if (imem_req !== 1'b0 || fd_valid !== 1'b0) begin failures++; $display("FAIL rw_drop: got req %b valid %b expected 0/0", imem_req, fd_valid); end
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || fd_valid !== 1'b0) begin failures++; $display("FAIL rw_newreq: got %b/%h/%b expected 1/00000100/0", imem_req, imem_addr, fd_valid); end
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        checks++; if (fd_valid !== 1'b1 || fd_next_pc !== 32'h104 || fd_ins !== (32'h100 ^ KEY)) begin failures++; $display("FAIL rw_word: got %b/%h/%h expected 1/00000104/%h", fd_valid, fd_next_pc, fd_ins, 32'h100 ^ KEY); end
    endtask

    // Redirect coincides with ack and pop: nothing survives.
    task automatic test_redirect_ack_pop();
        apply_reset();
        auto_ack = 1'b1;
        tick();
        tick();
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4 || fd_valid !== 1'b1) begin failures++; $display("FAIL rap_setup: got %b/%h/%b expected 1/00000004/1", imem_req, imem_addr, fd_valid); end
        redirect = 1'b1; redirect_pc = 32'h200; fd_ready = 1'b1;
        tick();
        redirect = 1'b0; fd_ready = 1'b0;
        checks++; if (fd_valid !== 1'b0 || imem_req !== 1'b0 || fd_ins !== 32'h0) begin failures++; $display("FAIL rap_flush: got %b/%b/%h expected 0/0/00000000", fd_valid, imem_req, fd_ins); end
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin failures++; $display("FAIL rap_newreq: got %b/%h expected 1/00000200", imem_req, imem_addr); end
        tick();
        checks++; if (fd_valid !== 1'b1 || fd_next_pc !== 32'h204) begin failures++; $display("FAIL rap_word: got %b/%h expected 1/00000204", fd_valid, fd_next_pc); end
    endtask

    // PC+4 wraps at the top of the address space.
    task automatic test_wrap();
        apply_reset();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_req: got %b/%h expected 1/fffffffc", imem_req, imem_addr); end
        auto_ack = 1'b1;
        tick();
        checks++; if (fd_valid !== 1'b1 || fd_next_pc !== 32'h0 || fd_ins !== 32'h2152_FFFC) begin failures++; $display("FAIL wrap_head: got %b/%h/%h expected 1/00000000/2152fffc", fd_valid, fd_next_pc, fd_ins); end
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_next: got %b/%h expected 1/00000000", imem_req, imem_addr); end
    endtask

    // Reset while a request is outstanding abandons it.
    task automatic test_reset_mid_wait();
        apply_reset();
        auto_ack = 1'b1;
        tick();
        tick();
        tick();
        auto_ack = 1'b0;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4 || fd_valid !== 1'b1) begin failures++; $display("FAIL rmw_setup: got %b/%h/%b expected 1/00000004/1", imem_req, imem_addr, fd_valid); end
        reset_n = 1'b0;
        tick();
        checks++; if (imem_req !== 1'b0 || fd_valid !== 1'b0 || imem_addr !== 32'h0) begin failures++; $display("FAIL rmw_reset: got %b/%b/%h expected 0/0/00000000", imem_req, fd_valid, imem_addr); end
        reset_n = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL rmw_restart: got %b/%h expected 1/00000000", imem_req, imem_addr); end
    endtask

`ifdef IF_ALIGN_FAULT_EN
    // Misaligned redirect raises a sticky fault and stops fetching.
    task automatic test_misaligned();
        int reqs;
        apply_reset();
        redirect = 1'b1; redirect_pc = 32'h102;
        tick();
        redirect = 1'b0;
        auto_ack = 1'b1;
        reqs = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (imem_req || fd_valid) reqs++;
        end
        checks++; if (fault !== 1'b1) begin failures++; $display("FAIL mis_fault: got %b expected 1", fault); end
        checks++; if (reqs !== 0) begin failures++; $display("FAIL mis_halt: got %0d active cycles expected 0", reqs); end
    endtask
`else
    // Low redirect bits are ignored and fetch continues aligned.
    task automatic test_misaligned();
        apply_reset();
        redirect = 1'b1; redirect_pc = 32'h302;
        tick();
        redirect = 1'b0;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin failures++; $display("FAIL mis_req: got %b/%h expected 1/00000300", imem_req, imem_addr); end
        auto_ack = 1'b1;
        tick();
        checks++; if (fd_valid !== 1'b1 || fd_next_pc !== 32'h304) begin failures++; $display("FAIL mis_head: got %b/%h expected 1/00000304", fd_valid, fd_next_pc); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_redirect_wait();
        test_redirect_ack_pop();
        test_wrap();
        test_reset_mid_wait();
        test_misaligned();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
